// File: rtl/mem_request_scheduler_pkg.sv
// Shared types and helpers for the core memory request scheduler: port indices,
// the request payload struct, the scheduler state type and round-robin pick.
package mem_request_scheduler_pkg;

  localparam int NUM_MEM_PORTS = 4;
  localparam int ADDR_W        = 30;
  localparam int RLEN_W        = 5;

  typedef logic [1:0] mem_port_id_t;

  localparam mem_port_id_t DCACHE = 2'd0;
  localparam mem_port_id_t ICACHE = 2'd1;
  localparam mem_port_id_t DMMU   = 2'd2;
  localparam mem_port_id_t IMMU   = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [RLEN_W-1:0] rlen;
    logic              rnw;
    logic              rmw;
  } mem_req_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } sched_state_e;

  // First eligible port strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic mem_port_id_t rr_pick(input logic [NUM_MEM_PORTS-1:0] eligible,
                                           input mem_port_id_t             last);
    mem_port_id_t pick;
    mem_port_id_t cand;
    logic         found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_MEM_PORTS; i++) begin
      cand = last + mem_port_id_t'(i);
      if (!found && eligible[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_request_scheduler_burst_len_fifo.sv
// Per-port FIFO of outstanding read burst lengths; the head is the burst whose
// beats are currently returning. Push and pop may occur in the same cycle.
module burst_len_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_pop,
  output logic [DATA_W-1:0]           o_head,
  output logic                        o_empty,
  output logic                        o_full,
  output logic [$clog2(DEPTH+1)-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler sharing one memory master port between D$, I$, DMMU and
// IMMU, with per-port read-burst credits and ack/rvalid demultiplexing.
module mem_request_scheduler
  import mem_request_scheduler_pkg::*;
#(
  parameter logic [NUM_MEM_PORTS-1:0] PORT_EN         = 4'b1111,
  parameter int                       MAX_OUTSTANDING = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MEM_PORTS-1:0]              req_request,
  input  logic [NUM_MEM_PORTS-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_MEM_PORTS-1:0][RLEN_W-1:0]  req_rlen,
  input  logic [NUM_MEM_PORTS-1:0]              req_rnw,
  input  logic [NUM_MEM_PORTS-1:0]              req_rmw,
  output logic [NUM_MEM_PORTS-1:0]              req_ack,
  output logic [NUM_MEM_PORTS-1:0]              req_rvalid,
  output logic                                  mem_request,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [RLEN_W-1:0]                     mem_rlen,
  output logic                                  mem_rnw,
  output logic                                  mem_rmw,
  output mem_port_id_t                          mem_id,
  input  logic                                  mem_ack,
  input  logic                                  mem_rvalid,
  input  mem_port_id_t                          mem_rid,
  output logic                                  quiescent,
  output logic                                  err_unexpected_rvalid
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  sched_state_e                               r_state;
  sched_state_e                               w_next_state;
  mem_req_t                                   r_req;
  mem_port_id_t                               r_id;
  mem_port_id_t                               r_last;
  logic [NUM_MEM_PORTS-1:0][RLEN_W-1:0]       r_beat;
  logic                                       r_err;

  logic                                       w_grant;
  logic                                       w_done;
  mem_port_id_t                               w_pick;
  logic [NUM_MEM_PORTS-1:0]                   w_eligible;
  logic [NUM_MEM_PORTS-1:0]                   w_push;
  logic [NUM_MEM_PORTS-1:0]                   w_pop;
  logic [NUM_MEM_PORTS-1:0]                   w_empty;
  logic [NUM_MEM_PORTS-1:0]                   w_full;
  logic [NUM_MEM_PORTS-1:0][RLEN_W-1:0]       w_head;
  logic [NUM_MEM_PORTS-1:0][CNT_W-1:0]        w_count;

  // Writes carry no read beats, so they bypass the credit check.
  always_comb begin
    for (int p = 0; p < NUM_MEM_PORTS; p++) begin
      w_eligible[p] = req_request[p] & PORT_EN[p] & (~w_full[p] | (~req_rnw[p] & ~req_rmw[p]));
      w_push[p]     = w_done & (r_req.rnw | r_req.rmw) & (r_id == mem_port_id_t'(p));
      req_rvalid[p] = mem_rvalid & (mem_rid == mem_port_id_t'(p)) & PORT_EN[p];
      w_pop[p]      = req_rvalid[p] & ~w_empty[p] & (r_beat[p] == w_head[p]);
    end
  end

  assign w_pick = rr_pick(w_eligible, r_last);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: if (|w_eligible) begin
        w_next_state = S_HOLD;
        w_grant      = 1'b1;
      end
      S_HOLD: if (mem_ack) begin
        w_next_state = S_IDLE;
        w_done       = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_id    <= '0;
      r_last  <= IMMU;
      r_beat  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_req <= '{addr: req_addr[w_pick], rlen: req_rlen[w_pick],
                   rnw:  req_rnw[w_pick],  rmw:  req_rmw[w_pick]};
        r_id  <= w_pick;
      end
      if (w_done) r_last <= r_id;
      if (mem_rvalid && w_empty[mem_rid]) r_err <= 1'b1;
      for (int p = 0; p < NUM_MEM_PORTS; p++) begin
        if (req_rvalid[p] && !w_empty[p]) begin
          r_beat[p] <= w_pop[p] ? '0 : r_beat[p] + 1'b1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_MEM_PORTS; p++) begin : g_port
    burst_len_fifo #(
      .DEPTH  (MAX_OUTSTANDING),
      .DATA_W (RLEN_W)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[p]),
      .i_data  (r_req.rlen),
      .i_pop   (w_pop[p]),
      .o_head  (w_head[p]),
      .o_empty (w_empty[p]),
      .o_full  (w_full[p]),
      .o_count (w_count[p])
    );
  end

  assign mem_request           = (r_state == S_HOLD);
  assign mem_addr              = r_req.addr;
  assign mem_rlen              = r_req.rlen;
  assign mem_rnw               = r_req.rnw;
  assign mem_rmw               = r_req.rmw;
  assign mem_id                = r_id;
  assign req_ack               = w_done ? (NUM_MEM_PORTS'(1) << r_id) : '0;
  assign quiescent             = (r_state == S_IDLE) & (w_count == '0);
  assign err_unexpected_rvalid = r_err;

endmodule
